// File: rtl/load_mem_reader.sv
// load_mem_reader: RV64 load unit issuing one aligned 64-bit read per request and returning the extended lane to writeback
module load_mem_reader #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [63:0]       wb_data,
    output logic              wb_err,
    output logic [CNT_W-1:0]  ld_count
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0] f3_q;
    logic acc, req_err, sx;
    logic [63:0] sh, ext;

    assign req_ready   = state == IDLE;
    assign mem_arvalid = state == ADDR;
    assign mem_rready  = state == DATA;
    assign wb_valid    = state == RESP;
    assign mem_araddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign acc         = req_valid && req_ready;
    assign req_err     = req_funct3 == 3'b111 ||
                         (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'd2 && |req_addr[1:0]) ||
                         (req_funct3[1:0] == 2'd3 && |req_addr[2:0]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (acc ? (req_err ? RESP : ADDR) : IDLE) :
                   state == ADDR ? (mem_arready ? DATA : ADDR) :
                   state == DATA ? (mem_rvalid ? RESP : DATA) :
                   (wb_ready ? IDLE : RESP);
    end

    // Shift the addressed lane down to bit 0, then size and extend it
    always_comb begin
        sx  = ~f3_q[2];
        sh  = mem_rdata >> {addr_q[2:0], 3'b000};
        ext = f3_q[1:0] == 2'd0 ? {{56{sx & sh[7]}}, sh[7:0]} :
              f3_q[1:0] == 2'd1 ? {{48{sx & sh[15]}}, sh[15:0]} :
              f3_q[1:0] == 2'd2 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q   <= '0;
            f3_q     <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
            ld_count <= '0;
        end else begin
            if (acc) begin
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wb_rd   <= req_rd;
                wb_err  <= req_err;
                wb_data <= '0;
            end
            if (state == DATA && mem_rvalid) wb_data <= ext;
            if (wb_valid && wb_ready) ld_count <= ld_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_load_mem_reader.sv
// tb_load_mem_reader: randomized and directed loads checked every cycle against a byte-level load model
module tb_load_mem_reader;
    logic        clk, rst_n, req_valid, req_ready, mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic        wb_valid, wb_ready, wb_err;
    logic [63:0] req_addr, mem_araddr, mem_rdata, wb_data;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, wb_rd;
    logic [31:0] ld_count;

    int checks = 0, failures = 0;
    logic mon = 0, busy = 0;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data, exp_araddr;
    logic        exp_err;
    int unsigned exp_count = 0;

    load_mem_reader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .ld_count(ld_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] rd,
                                  output logic [63:0] d, output logic e);
        int sz, off;
        logic [63:0] v;
        sz  = 1 << f3[1:0];
        off = int'(a[2:0]);
        e   = (f3 == 3'b111) || (a % 64'(sz) != 0);
        v   = '0;
        if (!e) begin
            for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
            if (!f3[2] && sz < 8 && v[8*sz-1])
                for (int i = sz * 8; i < 64; i++) v[i] = 1'b1;
        end
        d = e ? 64'd0 : v;
    endfunction

    always @(negedge clk) if (rst_n && mon) begin
        chk("ld_count", ld_count, exp_count);
        chk("req_ready", req_ready, !busy);
        if (!busy) chk("idle_outs", {wb_valid, mem_arvalid, mem_rready}, 0);
        if (busy && exp_err) chk("err_no_mem", {mem_arvalid, mem_rready}, 0);
        if (mem_arvalid) chk("araddr", mem_araddr, exp_araddr);
        if (wb_valid) begin
            chk("wb_rd", wb_rd, exp_rd);
            chk("wb_data", wb_data, exp_data);
            chk("wb_err", wb_err, exp_err);
        end
    end

    task automatic do_load(input logic [63:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] rdata, input int ard, input int rdd, input int wbd);
        int n;
        logic [63:0] ed;
        logic ee;
        model(a, f3, rdata, ed, ee);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", req_ready, 1);
        req_valid = 1; req_addr = a; req_funct3 = f3; req_rd = rd;
        @(posedge clk); #1;
        exp_rd = rd; exp_data = ed; exp_err = ee; exp_araddr = {a[63:3], 3'b000}; busy = 1;
        req_valid = 1'($urandom_range(0, 1)); req_addr = {$urandom, $urandom};
        req_funct3 = 3'($urandom); req_rd = 5'($urandom);
        if (!ee) begin
            n = 0;
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
            forever begin
                mem_arready = n >= ard;
                @(negedge clk);
                chk("arvalid", mem_arvalid, 1);
                if (mem_arready || !mem_arvalid) break;
                n++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            mem_arready = 0;
            n = 0;
            forever begin
                mem_rvalid = n >= rdd;
                mem_rdata = mem_rvalid ? rdata : {$urandom, $urandom};
                @(negedge clk);
                chk("rready", mem_rready, 1);
                if (mem_rvalid || !mem_rready) break;
                n++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            mem_rvalid = 0;
        end
        n = 0;
        forever begin
            wb_ready = n >= wbd;
            mem_arready = 1'($urandom_range(0, 1));
            if (wb_ready) req_valid = 0;
            @(negedge clk);
            chk("wb_valid", wb_valid, 1);
            if (wb_ready || !wb_valid) break;
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wb_ready = 0; mem_arready = 0; busy = 0; exp_count++;
    endtask

    initial begin
        logic [63:0] d;
        logic e;
        rst_n = 0; req_valid = 0; req_addr = 0; req_funct3 = 0; req_rd = 0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 0;
        model(64'h80000008, 3'd3, 64'h1122334455667788, d, e); chk("m_ld", {e, d}, {1'b0, 64'h1122334455667788});
        model(64'h80000003, 3'd0, 64'h80000000, d, e); chk("m_lb", d, 64'hFFFFFFFFFFFFFF80);
        model(64'h80000003, 3'd4, 64'h80000000, d, e); chk("m_lbu", d, 64'h80);
        model(64'h80000004, 3'd2, 64'h8765432100000000, d, e); chk("m_lw", d, 64'hFFFFFFFF87654321);
        model(64'h80000004, 3'd6, 64'h8765432100000000, d, e); chk("m_lwu", d, 64'h87654321);
        model(64'h80000006, 3'd1, 64'h7FFF000000000000, d, e); chk("m_lh", d, 64'h7FFF);
        model(64'h80000002, 3'd1, 64'h80010000, d, e); chk("m_lh_neg", d, 64'hFFFFFFFFFFFF8001);
        model(64'h80000002, 3'd5, 64'h80010000, d, e); chk("m_lhu", d, 64'h8001);
        model(64'h80000001, 3'd1, 64'hFFFF, d, e); chk("m_lh_mis", {e, d}, {1'b1, 64'd0});
        model(64'h80000000, 3'd7, 64'hFFFF, d, e); chk("m_ill", {e, d}, {1'b1, 64'd0});
        model(64'h80000004, 3'd3, 64'hFFFF, d, e); chk("m_ld_mis", e, 1);
        model(64'h80000002, 3'd2, 64'hFFFF, d, e); chk("m_lw_mis", e, 1);
        #2;
        chk("rst_ctl", {mem_arvalid, mem_rready, wb_valid, wb_err}, 0);
        chk("rst_data", {wb_rd, wb_data, mem_araddr, ld_count}, 0);
        @(posedge clk); #1;
        rst_n = 1; mon = 1;
        do_load(64'h80000008, 3'd3, 5'd1, 64'h1122334455667788, 0, 0, 0);
        do_load(64'h80000003, 3'd0, 5'd2, 64'h0000000080000000, 0, 0, 0);
        do_load(64'h80000003, 3'd4, 5'd3, 64'h0000000080000000, 1, 2, 1);
        do_load(64'h80000004, 3'd2, 5'd4, 64'h8765432100000000, 0, 0, 0);
        do_load(64'h80000004, 3'd6, 5'd5, 64'h8765432100000000, 0, 1, 0);
        do_load(64'h80000006, 3'd1, 5'd6, 64'h7FFF000000000000, 0, 0, 0);
        do_load(64'h80000001, 3'd1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0);
        do_load(64'h80000000, 3'd7, 5'd8, 64'hFFFFFFFFFFFFFFFF, 0, 0, 2);
        do_load(64'h80000010, 3'd3, 5'd9, 64'hCAFEF00DDEADBEEF, 5, 0, 3);
        chk("count_after_stall", ld_count, 9);
        for (int k = 0; k < 150; k++) begin
            logic [63:0] a;
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            a = {$urandom | 32'h1, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            do_load(a, f3, 5'($urandom), {$urandom, $urandom}, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
        mon = 0;
        req_valid = 1; req_addr = 64'h80000010; req_funct3 = 3'd3; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 0; mem_arready = 1;
        @(posedge clk); #1;
        mem_arready = 0;
        @(negedge clk);
        chk("pre_rst_rready", mem_rready, 1);
        #1;
        rst_n = 0;
        #1;
        chk("rst_ctl2", {mem_arvalid, mem_rready, wb_valid, wb_err}, 0);
        chk("rst_data2", {wb_rd, wb_data, mem_araddr, ld_count}, 0);
        chk("rst_req_ready", req_ready, 1);
        mem_rvalid = 1; mem_rdata = 64'h0123456789ABCDEF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {wb_valid, mem_rready, req_ready}, 3'b001);
        end
        @(posedge clk); #1;
        mem_rvalid = 0; busy = 0; exp_count = 0; mon = 1;
        do_load(64'h80000020, 3'd2, 5'd11, 64'h00000000FFFFFFFE, 0, 0, 0);
        chk("final_count", ld_count, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
